// File: rtl/jstk_dir_decoder.sv
// rtl/jstk_dir_decoder.sv - joystick axis to filtered direction levels with auto-repeat pulses
module jstk_dir_decoder #(
    parameter int AXIS_W         = 10,
    parameter int CENTER         = 512,
    parameter int DEADZONE       = 200,
    parameter int HYST           = 32,
    parameter int STABLE_SAMPLES = 3,
    parameter int REPEAT_DELAY   = 10,
    parameter int REPEAT_RATE    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [AXIS_W-1:0] x_pos,
    input  logic [AXIS_W-1:0] y_pos,
    input  logic              btn_trig,
    input  logic              btn_jstk,
    output logic [3:0]        dir_level,
    output logic [3:0]        dir_pulse,
    output logic [1:0]        btn_level,
    output logic [1:0]        btn_press
);

    // Thresholds clamped into the axis range so extreme parameter choices stay well defined
    localparam int MAXV      = (1 << AXIS_W) - 1;
    localparam int HI_ON_I   = CENTER + DEADZONE;
    localparam int HI_OFF_I  = CENTER + DEADZONE - HYST;
    localparam int LO_ON_I   = CENTER - DEADZONE;
    localparam int LO_OFF_I  = CENTER - DEADZONE + HYST;
    localparam int HI_ON     = (HI_ON_I  > MAXV) ? MAXV : ((HI_ON_I  < 0) ? 0 : HI_ON_I);
    localparam int HI_OFF    = (HI_OFF_I > MAXV) ? MAXV : ((HI_OFF_I < 0) ? 0 : HI_OFF_I);
    localparam int LO_ON     = (LO_ON_I  > MAXV) ? MAXV : ((LO_ON_I  < 0) ? 0 : LO_ON_I);
    localparam int LO_OFF    = (LO_OFF_I > MAXV) ? MAXV : ((LO_OFF_I < 0) ? 0 : LO_OFF_I);
    localparam logic [AXIS_W-1:0] HI_ON_T  = AXIS_W'(HI_ON);
    localparam logic [AXIS_W-1:0] HI_OFF_T = AXIS_W'(HI_OFF);
    localparam logic [AXIS_W-1:0] LO_ON_T  = AXIS_W'(LO_ON);
    localparam logic [AXIS_W-1:0] LO_OFF_T = AXIS_W'(LO_OFF);
    localparam logic [3:0]        STABLE_T = 4'(STABLE_SAMPLES);
    localparam logic [7:0]        DELAY_T  = 8'(REPEAT_DELAY);
    localparam logic [7:0]        RATE_T   = 8'(REPEAT_RATE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rpt_state_t;

    logic [3:0] cand;
    logic [3:0] prev_cand;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       commit;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pulse_raw;
    logic [1:0] btn_new;

    rpt_state_t state      [4];
    rpt_state_t state_next [4];
    logic [7:0] timer      [4];
    logic [7:0] timer_next [4];

    assign btn_new = {btn_trig, btn_jstk};

    // Raw candidate with hysteresis: an already committed bit uses the relaxed release threshold
    always_comb begin
        cand    = 4'b0000;
        cand[3] = dir_level[3] ? (y_pos > HI_OFF_T) : (y_pos > HI_ON_T);
        cand[2] = dir_level[2] ? (y_pos < LO_OFF_T) : (y_pos < LO_ON_T);
        cand[1] = dir_level[1] ? (x_pos < LO_OFF_T) : (x_pos < LO_ON_T);
        cand[0] = dir_level[0] ? (x_pos > HI_OFF_T) : (x_pos > HI_ON_T);
    end

    // Stability count for this sample and the resulting commit decision
    always_comb begin
        cnt_next = 4'd1;
        if (cand == prev_cand) begin
            cnt_next = (cnt >= STABLE_T) ? STABLE_T : cnt + 4'd1;
        end
        commit = sample_valid && (cnt_next == STABLE_T) && (cand != dir_level);
        rise   = commit ? (cand & ~dir_level) : 4'b0000;
        fall   = commit ? (~cand & dir_level) : 4'b0000;
    end

    // Filter, committed level and button registers; only sample cycles advance them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cand <= 4'b0000;
            cnt       <= 4'd0;
            dir_level <= 4'b0000;
            dir_pulse <= 4'b0000;
            btn_level <= 2'b00;
            btn_press <= 2'b00;
        end else begin
            // A pulse is suppressed right after another so no pulse ever spans two cycles
            dir_pulse <= pulse_raw & ~dir_pulse;
            btn_press <= sample_valid ? (btn_new & ~btn_level) : 2'b00;
            if (sample_valid) begin
                prev_cand <= cand;
                cnt       <= cnt_next;
                btn_level <= btn_new;
                if (commit) begin
                    dir_level <= cand;
                end
            end
        end
    end

    // Repeat FSM state and timer register, one per direction bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= S_IDLE;
                timer[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_next[i];
                timer[i] <= timer_next[i];
            end
        end
    end

    // Repeat FSM next state: the timer counts samples, expiring when it would reach zero
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_next[i] = state[i];
            timer_next[i] = timer[i];
            if (sample_valid) begin
                if (fall[i]) begin
                    state_next[i] = S_IDLE;
                    timer_next[i] = 8'd0;
                end else begin
                    case (state[i])
                        S_IDLE: begin
                            if (rise[i]) begin
                                state_next[i] = S_DELAY;
                                timer_next[i] = DELAY_T;
                            end
                        end
                        S_DELAY: begin
                            if (timer[i] <= 8'd1) begin
                                state_next[i] = S_REPEAT;
                                timer_next[i] = RATE_T;
                            end else begin
                                timer_next[i] = timer[i] - 8'd1;
                            end
                        end
                        S_REPEAT: begin
                            if (timer[i] <= 8'd1) begin
                                timer_next[i] = RATE_T;
                            end else begin
                                timer_next[i] = timer[i] - 8'd1;
                            end
                        end
                        default: begin
                            state_next[i] = S_IDLE;
                            timer_next[i] = 8'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Repeat FSM outputs: pulse on the initial press and on every timer expiry
    always_comb begin
        pulse_raw = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (sample_valid && !fall[i]) begin
                if (state[i] == S_IDLE) begin
                    pulse_raw[i] = rise[i];
                end else begin
                    pulse_raw[i] = (timer[i] <= 8'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jstk_dir_decoder.sv
// tb/tb_jstk_dir_decoder.sv - scoreboard bench for jstk_dir_decoder
module tb_jstk_dir_decoder;

    localparam int W      = 10;
    localparam int C      = 512;
    localparam int DZ     = 200;
    localparam int HY     = 32;
    localparam int STABLE = 3;
    localparam int DLY    = 10;
    localparam int RATE   = 4;
    localparam int MAXV   = 1023;
    localparam int UP_ON  = (C + DZ > MAXV) ? MAXV : C + DZ;
    localparam int UP_OFF = (C + DZ - HY > MAXV) ? MAXV : C + DZ - HY;
    localparam int DN_ON  = (C - DZ < 0) ? 0 : C - DZ;
    localparam int DN_OFF = (C - DZ + HY < 0) ? 0 : C - DZ + HY;

    logic         clk;
    logic         rst;
    logic         sample_valid;
    logic [W-1:0] x_pos;
    logic [W-1:0] y_pos;
    logic         btn_trig;
    logic         btn_jstk;
    logic [3:0]   dir_level;
    logic [3:0]   dir_pulse;
    logic [1:0]   btn_level;
    logic [1:0]   btn_press;

    jstk_dir_decoder #(
        .AXIS_W(W), .CENTER(C), .DEADZONE(DZ), .HYST(HY),
        .STABLE_SAMPLES(STABLE), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .x_pos(x_pos), .y_pos(y_pos),
        .btn_trig(btn_trig), .btn_jstk(btn_jstk),
        .dir_level(dir_level), .dir_pulse(dir_pulse),
        .btn_level(btn_level), .btn_press(btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lvl;
        logic [3:0] pul;
        logic [1:0] bl;
        logic [1:0] bp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state: committed level, filter history, samples since each press
    logic [3:0] m_lvl;
    logic [3:0] m_prev;
    int         m_cnt;
    int         m_age [4];
    logic [1:0] m_btn;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl  = 4'b0000;
        m_prev = 4'b0000;
        m_cnt  = 0;
        m_btn  = 2'b00;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    // Pulses happen at age 0 (press), age DLY, then every RATE samples after that
    task automatic model_step(input int x, input int y, input logic bt, input logic bj);
        logic [3:0] c;
        logic [3:0] nl;
        exp_t       e;
        c[3] = m_lvl[3] ? (y > UP_OFF) : (y > UP_ON);
        c[2] = m_lvl[2] ? (y < DN_OFF) : (y < DN_ON);
        c[1] = m_lvl[1] ? (x < DN_OFF) : (x < DN_ON);
        c[0] = m_lvl[0] ? (x > UP_OFF) : (x > UP_ON);
        if (c == m_prev) m_cnt = (m_cnt + 1 > STABLE) ? STABLE : m_cnt + 1;
        else             m_cnt = 1;
        m_prev = c;
        nl    = (m_cnt == STABLE) ? c : m_lvl;
        e.pul = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (nl[i] && !m_lvl[i]) begin
                m_age[i] = 0;
                e.pul[i] = 1'b1;
            end else if (nl[i] && m_lvl[i]) begin
                m_age[i]++;
                if (m_age[i] == DLY || (m_age[i] > DLY && (m_age[i] - DLY) % RATE == 0))
                    e.pul[i] = 1'b1;
            end
        end
        m_lvl = nl;
        e.lvl = m_lvl;
        e.bp  = {bt, bj} & ~m_btn;
        m_btn = {bt, bj};
        e.bl  = m_btn;
        exp_q.push_back(e);
    endtask

    task automatic do_sample(input int x, input int y, input logic bt, input logic bj);
        @(negedge clk);
        x_pos        = W'(x);
        y_pos        = W'(y);
        btn_trig     = bt;
        btn_jstk     = bj;
        sample_valid = 1'b1;
        model_step(x, y, bt, bj);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_level"}, {4'h0, dir_level}, 8'h00);
        chk({tag, "_pulse"}, {4'h0, dir_pulse}, 8'h00);
        chk({tag, "_btn"}, {4'h0, btn_level, btn_press}, 8'h00);
    endtask

    // Monitor: after each sampled edge pop the expectation, then confirm pulses drop next cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (sample_valid && !rst) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 8'h01, 8'h00);
                end else begin
                    e = exp_q.pop_front();
                    chk("dir_level", {4'h0, dir_level}, {4'h0, e.lvl});
                    chk("dir_pulse", {4'h0, dir_pulse}, {4'h0, e.pul});
                    chk("btn_level", {6'h0, btn_level}, {6'h0, e.bl});
                    chk("btn_press", {6'h0, btn_press}, {6'h0, e.bp});
                end
                @(posedge clk);
                #1;
                chk("pulse_one_cycle", {dir_pulse, btn_press, 2'b00}, 8'h00);
            end
        end
    end

    initial begin
        int x;
        int y;
        int run;
        logic bt;
        logic bj;
        rst          = 1'b1;
        sample_valid = 1'b0;
        x_pos        = '0;
        y_pos        = '0;
        btn_trig     = 1'b0;
        btn_jstk     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // press up, hold for 25 samples, then hysteresis hold and release
        for (int i = 0; i < 25; i++) do_sample(512, 800, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  do_sample(512, 700, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  do_sample(512, 680, 1'b0, 1'b0);
        // glitchy sequence that must not commit
        do_sample(512, 800, 1'b0, 1'b0);
        do_sample(512, 800, 1'b0, 1'b0);
        do_sample(512, 512, 1'b0, 1'b0);
        do_sample(512, 800, 1'b0, 1'b0);
        do_sample(512, 800, 1'b0, 1'b0);
        do_sample(512, 512, 1'b0, 1'b0);
        // diagonal corner held into the repeat phase
        for (int i = 0; i < 18; i++) do_sample(1023, 1023, 1'b0, 1'b0);
        // asynchronous reset in the middle of a cycle
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("mid_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)  do_sample(512, 512, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  do_sample(512, 800, 1'b0, 1'b0);
        // trigger held across samples
        for (int i = 0; i < 4; i++)  do_sample(512, 512, 1'b1, 1'b0);
        do_sample(512, 512, 1'b0, 1'b1);

        // random runs of held values so commits and repeats really occur
        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(0, 5))
                0: x = 512;  1: x = 300;  2: x = 330;
                3: x = 350;  4: x = 800;  default: x = $urandom_range(0, 1023);
            endcase
            case ($urandom_range(0, 5))
                0: y = 512;  1: y = 800;  2: y = 700;
                3: y = 680;  4: y = 200;  default: y = $urandom_range(0, 1023);
            endcase
            bt  = 1'($urandom_range(0, 1));
            bj  = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 14);
            for (int k = 0; k < run; k++) do_sample(x, y, bt, bj);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
